result_packer: RTL and testbench
================================

// Module: result_packer
// PURPOSE
//  Upstream feeder of the AHIM result buffer: takes OCR characters one per cycle and packs each plate into PIO_DATA_WIDTH words.
//  Each word carries a header byte; the block pushes words into the result buffer.
//  It tracks buffer occupancy from push/pop, so it never overflows the buffer; it back-pressures the OCR stage instead.
// PARAMETERS
//  CHAR_WIDTH       8     bits per character code; PIO_DATA_WIDTH % CHAR_WIDTH == 0, >= 2 slots per word
//  MAX_PLATE_CHARS  16    chars kept per plate; extra chars dropped, truncated flag set
//  TIMEOUT_CYCLES   1024  idle cycles before forced flush (RESULT_PACKER_TIMEOUT_EN only)
// PORTS
//  clk_in        in   1                sole clock
//  rst_n         in   1                reset, synchronous active-low
//  clear_buff    in   1                sync clear; same strobe that clears the result buffer
//  char_valid    in   1                char_data valid
//  char_data     in   CHAR_WIDTH       character code
//  char_last     in   1                qualifies char_valid: final char of plate
//  char_ready    out  1                char accepted when char_valid & char_ready
//  fifo_pop      in   1                consumer pop strobe seen by the result buffer
//  fifo_push     out  1                push strobe to result buffer (registered)
//  fifo_data     out  PIO_DATA_WIDTH   packed word (registered)
//  packer_error  out  1                sticky: pop observed while occupancy == 0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all state, occ and slots cleared; char_ready=0; fifo_push=0; fifo_data=0; packer_error=0.
//   char_ready=1 from the first cycle after reset release.
//  Word layout: SLOTS = PIO_DATA_WIDTH/CHAR_WIDTH-1 char slots; slot0 at [CHAR_WIDTH-1:0], ascending.
//   Header is the top CHAR_WIDTH bits: [msb]=last word of plate, [msb-1]=truncated, lower bits=valid char count in the word.
//   Unused slots = 0.
//  FSM FILL: accept char into next slot. A word is closed when the slots are full or on char_last.
//   On close, go to PUSH; char_ready=0 in PUSH.
//  FSM PUSH: if occ < RESULT_RAM_DEPTH-1, assert fifo_push for 1 cycle with fifo_data, then return to FILL with slots cleared.
//   Otherwise hold and retry each cycle.
//   Latency: closing char accepted at cycle N -> fifo_push at N+1 when credit is available.
//  Occupancy occ (0..RESULT_RAM_DEPTH-1): +1 on fifo_push, -1 on fifo_pop when occ > 0.
//   Push and pop in the same cycle -> occ unchanged.
//   A pop in the same cycle as a PUSH credit check counts: credit is computed from the registered occ, so a freed slot is usable next cycle.
//  fifo_pop with occ == 0: occ stays 0; packer_error set, sticky.
//  Plate char counter: chars after MAX_PLATE_CHARS are accepted and discarded; the truncated bit is set in the plate's final word.
//   char_last on a discarded char still closes the plate.
//   char_last with char_valid=0 is ignored.
//  char_last exactly on a full word boundary: that word carries last=1; no empty terminator word.
//  clear_buff (priority below reset): discard partial word and plate state; occ=0; packer_error=0; state=FILL; fifo_push=0 that cycle.
//   A char presented with clear_buff is not accepted (char_ready=0).
// CONFIGURATION
//  RESULT_PACKER_TIMEOUT_EN defined:
//   In FILL with >= 1 char of the current plate buffered, TIMEOUT_CYCLES cycles with no accepted char force a close.
//   The forced word carries last=1 and truncated=1. Counter restarts on every accepted char.
//  Not defined: no timer; a plate stays open until char_last.
// STRUCTURE
//  ahim_config_pkg holds PIO_DATA_WIDTH and RESULT_RAM_DEPTH (existing), plus new items:
//   packer_state_t enum {FILL, PUSH};
//   RESULT_HDR_LAST_BIT / RESULT_HDR_TRUNC_BIT constants, shared with the HPS driver decode.
//  One sub-module, result_credit_counter: owns occ, the credit flag and packer_error.
//   The FSM, slot assembly and the optional timer stay in result_packer.
// TESTING (PIO_DATA_WIDTH=32, CHAR_WIDTH=8, RESULT_RAM_DEPTH=8)
//  Plate 'A','B','7'(last) -> one push, fifo_data=32'h83374241.
//  Plate '1','2','3','4'(last) -> 32'h03333231 then 32'h81000034; char_ready low exactly 1 cycle per push.
//  7 words pushed with no pops -> occ=7, next closed word waits in PUSH, char_ready=0.
//   One fifo_pop -> push the following cycle.
//  fifo_pop at occ=0 -> packer_error=1 and stays set; clear_buff -> 0.
//   clear_buff mid-plate -> partial chars never pushed.
//  18 chars, last on 18th, MAX_PLATE_CHARS=16 -> 6 words; final word header 32'hC1 at [31:24].
//  TIMEOUT_EN, TIMEOUT_CYCLES=4: 'X' then idle 4 cycles -> push 32'hC1000058. Without macro, no push.

Source files
------------

// File: rtl/ahim_config_pkg.sv
// Shared AHIM configuration: bus/buffer sizing, packer FSM states and result-word header bit positions.
package ahim_config_pkg;
    localparam int PIO_DATA_WIDTH   = 32;
    localparam int RESULT_RAM_DEPTH = 8;

    typedef enum logic {FILL, PUSH} packer_state_t;

    // Header bit positions inside a result word, also decoded by the HPS driver.
    localparam int RESULT_HDR_LAST_BIT  = PIO_DATA_WIDTH - 1;
    localparam int RESULT_HDR_TRUNC_BIT = PIO_DATA_WIDTH - 2;
endpackage

// File: rtl/result_credit_counter.sv
// Mirrors result-buffer occupancy from push/pop strobes; grants push credit and flags pops on an empty buffer.
import ahim_config_pkg::*;

module result_credit_counter #(
    parameter int DEPTH = RESULT_RAM_DEPTH
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear_buff,
    input  logic push,
    input  logic pop,
    output logic credit,
    output logic packer_error
);
    localparam int OCC_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(DEPTH - 1);

    logic [OCC_W-1:0] occ_reg;
    logic             error_reg;

    always_ff @(posedge clk_in) begin
        if (!rst_n || clear_buff) begin
            occ_reg   <= '0;
            error_reg <= 1'b0;
        end else if (pop && occ_reg == '0) begin
            // Pop on an empty buffer is a consumer bug: count only the push.
            error_reg <= 1'b1;
            occ_reg   <= occ_reg + OCC_W'(push);
        end else if (push && !pop) begin
            occ_reg <= occ_reg + 1'b1;
        end else if (pop && !push) begin
            occ_reg <= occ_reg - 1'b1;
        end
    end

    assign credit       = occ_reg < OCC_LIMIT;
    assign packer_error = error_reg;
endmodule

// File: rtl/result_packer.sv
// Packs OCR plate characters into header-tagged result words with occupancy-based back-pressure.
// Optional idle-timeout flush when RESULT_PACKER_TIMEOUT_EN is defined.
import ahim_config_pkg::*;

module result_packer #(
    parameter int CHAR_WIDTH      = 8,
    parameter int MAX_PLATE_CHARS = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      clear_buff,
    input  logic                      char_valid,
    input  logic [CHAR_WIDTH-1:0]     char_data,
    input  logic                      char_last,
    output logic                      char_ready,
    input  logic                      fifo_pop,
    output logic                      fifo_push,
    output logic [PIO_DATA_WIDTH-1:0] fifo_data,
    output logic                      packer_error
);
    localparam int SLOTS     = PIO_DATA_WIDTH / CHAR_WIDTH - 1;
    localparam int CNT_W     = $clog2(SLOTS + 1);
    localparam int PLATE_W   = $clog2(MAX_PLATE_CHARS + 1);
    localparam int HDR_CNT_W = CHAR_WIDTH - 2;

    packer_state_t             state_reg;
    logic                      run_reg;
    logic [CHAR_WIDTH-1:0]     slot_reg [SLOTS];
    logic [CHAR_WIDTH-1:0]     slot_view [SLOTS];
    logic [CNT_W-1:0]          slot_cnt_reg;
    logic [PLATE_W-1:0]        plate_cnt_reg;
    logic                      trunc_reg;
    logic                      fifo_push_reg;
    logic [PIO_DATA_WIDTH-1:0] fifo_data_reg;
    logic [PIO_DATA_WIDTH-1:0] word_next;
    logic                      credit;

    logic             accept, keep, store, char_close, close, close_last, close_trunc;
    logic             timeout_close;
    logic [CNT_W-1:0] close_cnt;

    assign char_ready = run_reg && (state_reg == FILL) && !clear_buff;

    always_comb begin
        accept      = char_valid && char_ready;
        keep        = plate_cnt_reg < PLATE_W'(MAX_PLATE_CHARS);
        store       = accept && keep;
        close_cnt   = store ? slot_cnt_reg + 1'b1 : slot_cnt_reg;
        char_close  = accept && (char_last || (store && slot_cnt_reg == CNT_W'(SLOTS - 1)));
        close       = char_close || timeout_close;
        close_last  = timeout_close || (accept && char_last);
        close_trunc = timeout_close || (accept && char_last && (trunc_reg || !keep));
    end

    // Word image with the incoming char already dropped into its slot.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign slot_view[gi] = (store && slot_cnt_reg == CNT_W'(gi)) ? char_data : slot_reg[gi];
            assign word_next[gi*CHAR_WIDTH +: CHAR_WIDTH] = slot_view[gi];
        end
    endgenerate

    assign word_next[RESULT_HDR_LAST_BIT]                     = close_last;
    assign word_next[RESULT_HDR_TRUNC_BIT]                    = close_trunc;
    assign word_next[RESULT_HDR_TRUNC_BIT-1 -: HDR_CNT_W]     = HDR_CNT_W'(close_cnt);

`ifdef RESULT_PACKER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_reg;
    logic               plate_open;

    assign plate_open    = plate_cnt_reg != '0;
    assign timeout_close = run_reg && (state_reg == FILL) && !clear_buff && plate_open
                           && !accept && (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_n || clear_buff || accept || !plate_open || state_reg != FILL || timeout_close)
            timer_reg <= '0;
        else
            timer_reg <= timer_reg + 1'b1;
    end
`else
    assign timeout_close = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_reg     <= FILL;
            run_reg       <= 1'b0;
            slot_cnt_reg  <= '0;
            plate_cnt_reg <= '0;
            trunc_reg     <= 1'b0;
            fifo_push_reg <= 1'b0;
            fifo_data_reg <= '0;
            for (int i = 0; i < SLOTS; i++) slot_reg[i] <= '0;
        end else begin
            run_reg <= 1'b1;
            if (clear_buff) begin
                state_reg     <= FILL;
                slot_cnt_reg  <= '0;
                plate_cnt_reg <= '0;
                trunc_reg     <= 1'b0;
                fifo_push_reg <= 1'b0;
                for (int i = 0; i < SLOTS; i++) slot_reg[i] <= '0;
            end else begin
                case (state_reg)
                    FILL: begin
                        if (store)
                            plate_cnt_reg <= plate_cnt_reg + 1'b1;
                        else if (accept)
                            trunc_reg <= 1'b1;
                        if (close) begin
                            // The closed word lives in fifo_data_reg until it is pushed.
                            fifo_data_reg <= word_next;
                            fifo_push_reg <= credit;
                            state_reg     <= PUSH;
                            slot_cnt_reg  <= '0;
                            for (int i = 0; i < SLOTS; i++) slot_reg[i] <= '0;
                            if (close_last) begin
                                plate_cnt_reg <= '0;
                                trunc_reg     <= 1'b0;
                            end
                        end else if (store) begin
                            slot_reg     <= slot_view;
                            slot_cnt_reg <= close_cnt;
                        end
                    end
                    PUSH: begin
                        if (fifo_push_reg) begin
                            fifo_push_reg <= 1'b0;
                            state_reg     <= FILL;
                        end else if (credit) begin
                            fifo_push_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= FILL;
                endcase
            end
        end
    end

    result_credit_counter #(
        .DEPTH(RESULT_RAM_DEPTH)
    ) u_credit (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .clear_buff  (clear_buff),
        .push        (fifo_push_reg),
        .pop         (fifo_pop),
        .credit      (credit),
        .packer_error(packer_error)
    );

    assign fifo_push = fifo_push_reg;
    assign fifo_data = fifo_data_reg;
endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer (32-bit words, 8-bit chars, 8-deep buffer, 4-cycle timeout).
`timescale 1ns/1ps
module tb_result_packer;
    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_buff = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = '0;
    logic        char_last = 1'b0;
    logic        char_ready;
    logic        fifo_pop = 1'b0;
    logic        fifo_push;
    logic [31:0] fifo_data;
    logic        packer_error;

    int          tests = 0;
    int          fails = 0;
    int          push_cnt = 0;
    int          base;
    logic [31:0] last_data = '0;
    logic        seen;

    result_packer #(.CHAR_WIDTH(8), .MAX_PLATE_CHARS(16), .TIMEOUT_CYCLES(4)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .clear_buff(clear_buff),
        .char_valid(char_valid), .char_data(char_data), .char_last(char_last),
        .char_ready(char_ready), .fifo_pop(fifo_pop), .fifo_push(fifo_push),
        .fifo_data(fifo_data), .packer_error(packer_error)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (fifo_push) begin
            push_cnt  = push_cnt + 1;
            last_data = fifo_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Waits (bounded) for char_ready, then presents one char for one edge.
    task automatic send(input logic [7:0] c, input logic last);
        for (int k = 0; k < 20 && !char_ready; k++) tick();
        check("ready_wait", {31'd0, char_ready}, 32'd1);
        char_valid = 1'b1;
        char_data  = c;
        char_last  = last;
        tick();
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic pop_n(input int n);
        fifo_pop = 1'b1;
        repeat (n) tick();
        fifo_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_ready", {31'd0, char_ready}, 32'd0);
        check("rst_push",  {31'd0, fifo_push}, 32'd0);
        check("rst_data",  fifo_data, 32'h0);
        check("rst_err",   {31'd0, packer_error}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", {31'd0, char_ready}, 32'd1);

        // Plate A B 7
        base = push_cnt;
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        check("ab_no_push", {31'd0, fifo_push}, 32'd0);
        send(8'h37, 1'b1);
        check("ab7_push",  {31'd0, fifo_push}, 32'd1);
        check("ab7_data",  fifo_data, 32'h83374241);
        check("ab7_ready", {31'd0, char_ready}, 32'd0);
        tick();
        check("ab7_ready_back", {31'd0, char_ready}, 32'd1);
        check("ab7_count", push_cnt - base, 1);

        // Plate 1 2 3 4 : full word then last word
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        check("w1_push",  {31'd0, fifo_push}, 32'd1);
        check("w1_data",  fifo_data, 32'h03333231);
        check("w1_ready", {31'd0, char_ready}, 32'd0);
        tick();
        check("w1_ready_back", {31'd0, char_ready}, 32'd1);
        send(8'h34, 1'b1);
        check("w2_push", {31'd0, fifo_push}, 32'd1);
        check("w2_data", fifo_data, 32'h81000034);
        tick();
        check("w2_ready_back", {31'd0, char_ready}, 32'd1);

        // Drain (occ 3 -> 0), then fill to occ=7
        pop_n(3);
        base = push_cnt;
        for (int i = 0; i < 7; i++) send(8'h61 + 8'(i), 1'b1);
        tick();
        check("fill7_count", push_cnt - base, 7);
        send(8'h5A, 1'b1);
        check("full_no_push", {31'd0, fifo_push}, 32'd0);
        check("full_ready",   {31'd0, char_ready}, 32'd0);
        base = push_cnt;
        repeat (3) tick();
        check("full_hold_count", push_cnt - base, 0);
        check("full_hold_ready", {31'd0, char_ready}, 32'd0);
        pop_n(1);
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            tick();
            seen = fifo_push;
        end
        check("pop_frees_push", {31'd0, seen}, 32'd1);
        check("pop_push_data",  fifo_data, 32'h8100005A);
        tick();

        // Drain exactly to occ=0, then underflow pop
        pop_n(7);
        check("no_err_at_zero", {31'd0, packer_error}, 32'd0);
        pop_n(1);
        check("err_set", {31'd0, packer_error}, 32'd1);
        repeat (2) tick();
        check("err_sticky", {31'd0, packer_error}, 32'd1);

        // Partial plate discarded by clear; char presented with clear is dropped
        send(8'h50, 1'b0);
        send(8'h51, 1'b0);
        clear_buff = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h53;
        #1;
        check("clr_ready", {31'd0, char_ready}, 32'd0);
        tick();
        clear_buff = 1'b0;
        char_valid = 1'b0;
        check("clr_err",  {31'd0, packer_error}, 32'd0);
        check("clr_push", {31'd0, fifo_push}, 32'd0);
        send(8'h52, 1'b1);
        check("clr_next_data", fifo_data, 32'h81000052);
        tick();

        // 18-char plate: truncated at 16, six words (occ 1 -> 0 first)
        pop_n(1);
        base = push_cnt;
        for (int i = 0; i < 18; i++) send(8'h61 + 8'(i), i == 17);
        tick();
        check("trunc_count", push_cnt - base, 6);
        check("trunc_hdr",   {24'd0, last_data[31:24]}, 32'h000000C1);
        check("trunc_data",  last_data, 32'hC1000070);

        // Idle timeout (occ 6, credit available)
        base = push_cnt;
        send(8'h58, 1'b0);
`ifdef RESULT_PACKER_TIMEOUT_EN
        repeat (3) tick();
        check("to_early", push_cnt - base, 0);
        tick();
        check("to_push", {31'd0, fifo_push}, 32'd1);
        check("to_data", fifo_data, 32'hC1000058);
        tick();
`else
        repeat (10) tick();
        check("no_to_push", push_cnt - base, 0);
        send(8'h59, 1'b1);
        check("no_to_close", fifo_data, 32'h82005958);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
